// File: rtl/icap_cfg_loader.sv
// Drains config bytes from a FWFT FIFO, packs them MSB-first into 32-bit words
// and issues one ICAP write per word, with a starvation timeout.
`timescale 1ns/1ps
module icap_cfg_loader #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1023,
  parameter int BIT_SWAP  = 1
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  input  logic [DATA_SIZE-1:0] fifo_rdata,
  input  logic                 fifo_rempty,
  output logic                 fifo_rinc,
  output logic                 icap_csib,
  output logic                 icap_rdwrb,
  output logic [31:0]          icap_i,
  input  logic                 icap_busy,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] remaining;
  logic [1:0]           byte_idx;
  logic [11:0]          to_cnt;
  logic [31:0]          asm_word;
  logic [7:0]           in_byte;
  logic [31:0]          next_word;

  always_comb begin
    in_byte = '0;
    for (int b = 0; b < 8; b++) begin
      in_byte[b] = (BIT_SWAP != 0) ? fifo_rdata[7-b] : fifo_rdata[b];
    end
  end

  assign next_word = {asm_word[23:0], in_byte};
  assign fifo_rinc = (state == FETCH) && !fifo_rempty;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  // icap_busy is sampled on the edge before the write cycle so that the
  // strobe, direction and data can all leave straight from flops.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state      <= IDLE;
      remaining  <= '0;
      byte_idx   <= '0;
      to_cnt     <= '0;
      asm_word   <= '0;
      error      <= 1'b0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b1;
      icap_i     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= word_count;
            error     <= 1'b0;
            byte_idx  <= '0;
            to_cnt    <= '0;
            state     <= (word_count == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (fifo_rinc) begin
            asm_word <= next_word;
            byte_idx <= byte_idx + 2'd1;
            to_cnt   <= '0;
            if (byte_idx == 2'd3) begin
              state <= WRITE;
              if (!icap_busy) begin
                icap_csib  <= 1'b0;
                icap_rdwrb <= 1'b0;
                icap_i     <= next_word;
              end
            end
          end else if (to_cnt == TO_LAST) begin
            state <= ERR;
          end else begin
            to_cnt <= to_cnt + 12'd1;
          end
        end
        WRITE: begin
          if (!icap_csib) begin
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b1;
            remaining  <= remaining - CNT_WIDTH'(1);
            byte_idx   <= '0;
            state      <= (remaining == CNT_WIDTH'(1)) ? DONE : FETCH;
          end else if (!icap_busy) begin
            icap_csib  <= 1'b0;
            icap_rdwrb <= 1'b0;
            icap_i     <= asm_word;
          end
        end
        DONE: state <= IDLE;
        ERR: begin
          error <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/icap_cfg_loader.md
# icap_cfg_loader

Single-clock sequencer on the read side of the configuration-stream asynchronous FIFO. It drains 8-bit bytes from the FIFO read port, assembles them MSB-first into 32-bit words and writes each word to the ICAP primitive. It counts a requested number of words and reports completion or a starvation timeout to the host-side control logic.

## Interface
- `DATA_SIZE`, default 8: FIFO data width. Only 8 is supported.
- `CNT_WIDTH`, default 16: width of the word counter.
- `TIMEOUT`, default 1023: consecutive empty-FIFO cycles in FETCH before abort. Must be 1 to 2^12-1.
- `BIT_SWAP`, default 1: 1 reverses the bit order within each byte (ICAP SelectMAP ordering); 0 passes bytes unchanged.

Ports:
- `rclk` in, 1: clock. Same clock as the FIFO read domain.
- `rrst` in, 1: reset. Synchronous, active-high.
- `start` in, 1: begin a load. Sampled only in IDLE.
- `word_count` in, CNT_WIDTH: number of 32-bit words to write. Captured when `start` is accepted.
- `busy` out, 1: high in every non-IDLE state.
- `done` out, 1: one-cycle pulse when the load completes.
- `error` out, 1: sticky timeout flag. Cleared by `rrst` or by an accepted `start`.
- `fifo_rdata` in, DATA_SIZE: FIFO read data. First-word-fall-through: valid whenever `fifo_rempty` is 0.
- `fifo_rempty` in, 1: FIFO empty flag.
- `fifo_rinc` out, 1: FIFO read increment.
- `icap_csib` out, 1: ICAP chip select, active-low.
- `icap_rdwrb` out, 1: ICAP direction. 0 means write.
- `icap_i` out, 32: ICAP write data.
- `icap_busy` in, 1: ICAP BUSY. A write is not issued while it is high.

## Operation
- States: IDLE, FETCH, WRITE, DONE, ERR.
- IDLE:
  - On `start`=1, capture `word_count` into `remaining`, clear `error` and the byte index.
  - `word_count`=0 goes to DONE. Otherwise go to FETCH.
- FETCH:
  - `fifo_rinc` = (state==FETCH) & !`fifo_rempty`. This is combinational and is never asserted in any other state.
  - On each cycle with `fifo_rinc`=1, shift the byte (after optional bit swap) into a 32-bit assembly register, MSB first, and increment the 2-bit byte index.
  - When the 4th byte is taken, go to WRITE.
  - A timeout counter increments on each empty cycle and clears on each byte taken.
  - When the timeout counter reaches TIMEOUT, go to ERR.
- WRITE:
  - If `icap_busy`=0: drive `icap_csib`=0, `icap_rdwrb`=0 and `icap_i`=assembled word for exactly one cycle, then decrement `remaining`.
  - After that write, `remaining` reaching 0 goes to DONE; otherwise go to FETCH with the byte index at 0.
  - If `icap_busy`=1: hold in WRITE with `icap_csib`=1 until `icap_busy` falls.
- DONE: `done`=1 for one cycle, then go to IDLE.
- ERR: set `error`=1, then go to IDLE. No partial word is written. Leftover FIFO bytes stay in the FIFO; the host flushes or resets the FIFO.
- `icap_csib`, `icap_rdwrb` and `icap_i` are registered. `icap_i` holds its last value while `icap_csib`=1.
- `icap_rdwrb` is 0 only during the write cycle; it is 1 in all other cycles.
- `start` while `busy`=1 is ignored.
- `rrst` asserted mid-load aborts in the next cycle:
  - all state clears;
  - `error` is not set and `done` is not pulsed;
  - the byte already read from the FIFO is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `fifo_rinc`=0, `icap_csib`=1, `icap_rdwrb`=1, `icap_i`=0. State is IDLE.
- `start` sampled at edge 0 gives FETCH in cycle 1.
- With a non-empty FIFO and `icap_busy`=0:
  - 4 FETCH cycles, then 1 WRITE cycle, per word: 5 cycles/word.
  - The last WRITE is followed by DONE in the next cycle.
  - `done` is in cycle 5·N+1 after the start edge.
- `word_count`=0: `done` in cycle 1, with no FIFO reads.
- Each empty FIFO cycle in FETCH adds exactly 1 cycle.
- Each `icap_busy`=1 cycle in WRITE adds exactly 1 cycle.
- Timeout fires on the TIMEOUT-th consecutive empty FETCH cycle. `error` is visible 2 cycles later (ERR, then IDLE); `busy` drops in the same cycle.

## Test plan
- Reset: hold `rrst` 2 cycles with arbitrary inputs -> every output at its reset value; `fifo_rinc`=0 even with a non-empty FIFO.
- BIT_SWAP=0, `word_count`=2, FIFO preloaded AA 99 55 66 20 00 00 00 -> `icap_i`=0xAA995566 in cycle 5 and 0x20000000 in cycle 10 with `icap_csib`=0 only in those cycles; `done` in cycle 11; 8 `fifo_rinc` pulses.
- BIT_SWAP=1, `word_count`=1, bytes AA 99 55 66 -> single write of 0x5599AA66.
- Starvation: `word_count`=1, TIMEOUT=8, push 2 bytes then nothing -> `error`=1, `busy`=0, no `icap_csib` low, no `done`; next `start` clears `error`.
- Back-pressure: `icap_busy`=1 for 3 cycles at WRITE entry -> write is delayed 3 cycles and issued exactly once with the correct data.
- Corners: `word_count`=0 -> `done` in cycle 1 with no reads; `start` while busy is ignored (count unchanged); `rrst` during the 3rd FETCH byte -> IDLE next cycle, with `done`=0 and `error`=0.
